// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multiply/divide engine: operation selector,
// FSM state encoding and the iteration count of the sequential datapaths.
package selector;

  typedef enum logic [3:0] {
    MULDIV_MULT,
    MULDIV_MULTU,
    MULDIV_DIV,
    MULDIV_DIVU,
    MULDIV_MADD,
    MULDIV_MADDU,
    MULDIV_MSUB,
    MULDIV_MSUBU,
    MULDIV_NCARE
  } muldiv_funct_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIXUP,
    S_DONE
  } muldiv_state_t;

  localparam int MULDIV_ITER = 32;

endpackage

// File: rtl/muldiv_seq_divider.sv
// Restoring-division datapath on unsigned magnitudes; one quotient bit per step,
// stepped by the parent's iteration counter.
module muldiv_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // The dividend shifts out of the quotient register MSB-first while quotient bits shift in.
  assign shifted = {remainder, quotient[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (load) begin
      dvsr      <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        remainder <= diff[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide/accumulate engine with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle multiplier.
module muldiv_unit
  import selector::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  muldiv_funct_t    funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(MULDIV_ITER);

  muldiv_state_t      state;
  muldiv_funct_t      op;
  logic [CW-1:0]      cnt;
  logic               sign_a, sign_b, b_zero;
  logic [WIDTH-1:0]   mcand, acc_hi, acc_lo;
  logic [2*WIDTH-1:0] prod;

  logic               op_signed, accept, start_div;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] prod_fix, acc_res;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_signed = funct inside {MULDIV_MULT, MULDIV_DIV, MULDIV_MADD, MULDIV_MSUB};
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
  assign accept    = (state == S_IDLE) && start && !flush && (funct != MULDIV_NCARE);
  assign start_div = accept && (funct inside {MULDIV_DIV, MULDIV_DIVU});
  assign busy      = (state != S_IDLE);

  muldiv_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_div),
    .step      ((state == S_DIV) && !flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

`ifndef MULDIV_FAST_MUL_EN
  logic [WIDTH:0] psum;
  assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
`endif

  // Sign correction and accumulate; a zero divisor always yields an all-ones quotient.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    acc_res  = prod_fix;
    if (op inside {MULDIV_MADD, MULDIV_MADDU})
      acc_res = {acc_hi, acc_lo} + prod_fix;
    else if (op inside {MULDIV_MSUB, MULDIV_MSUBU})
      acc_res = {acc_hi, acc_lo} - prod_fix;
    quo_fix = b_zero ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
    rem_fix = sign_a ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op     <= MULDIV_NCARE;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      prod   <= '0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              op     <= funct;
              sign_a <= op_signed & a[WIDTH-1];
              sign_b <= op_signed & b[WIDTH-1];
              b_zero <= (b == '0);
              mcand  <= a_mag;
              prod   <= {{WIDTH{1'b0}}, b_mag};
              acc_hi <= hi_in;
              acc_lo <= lo_in;
              cnt    <= CW'(MULDIV_ITER - 1);
              state  <= start_div ? S_DIV : S_MUL;
            end
          end
          S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
            prod  <= {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, prod[WIDTH-1:0]};
            state <= S_FIXUP;
`else
            // Multiplier bits retire from the low half as partial sums fill the high half.
            prod <= prod[0] ? {psum, prod[WIDTH-1:1]}
                            : {1'b0, prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:1]};
            cnt  <= cnt - 1'b1;
            if (cnt == '0) state <= S_FIXUP;
`endif
          end
          S_DIV: begin
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= S_FIXUP;
          end
          S_FIXUP: begin
            if (op inside {MULDIV_DIV, MULDIV_DIVU}) begin
              hi_out <= rem_fix;
              lo_out <= quo_fix;
            end else begin
              hi_out <= acc_res[2*WIDTH-1:WIDTH];
              lo_out <= acc_res[WIDTH-1:0];
            end
            done  <= 1'b1;
            state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a reference model feeds a result queue
// that a done-triggered monitor drains; handshake timing is checked per operation.
module tb_muldiv_unit;
  import selector::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int mulLat = 3;
`else
  localparam int mulLat = 34;
`endif
  localparam int divLat   = 34;
  localparam int rstCycle = (mulLat > 20) ? 20 : 2;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } result_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  muldiv_funct_t funct = MULDIV_NCARE;
  logic [W-1:0]  a = '0, b = '0, hi_in = '0, lo_in = '0;
  logic [W-1:0]  hi_out, lo_out;
  logic          busy, done;

  int      checks = 0;
  int      errors = 0;
  result_t expQ[$];
  result_t lastExp;
  result_t monExp;
  logic    sawDone;

  muldiv_funct_t opTable[8] = '{MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU,
                                MULDIV_MADD, MULDIV_MADDU, MULDIV_MSUB, MULDIV_MSUBU};

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct  (funct),
    .a      (a),
    .b      (b),
    .hi_in  (hi_in),
    .lo_in  (lo_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic result_t modelResult(input muldiv_funct_t f, input logic [W-1:0] av,
                                          input logic [W-1:0] bv, input logic [W-1:0] hv,
                                          input logic [W-1:0] lv);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, acc, r;
    sa  = {{32{av[31]}}, av};
    sb  = {{32{bv[31]}}, bv};
    ua  = {32'b0, av};
    ub  = {32'b0, bv};
    acc = {hv, lv};
    r   = '0;
    case (f)
      MULDIV_MULT:  r = sa * sb;
      MULDIV_MULTU: r = ua * ub;
      MULDIV_MADD:  r = acc + sa * sb;
      MULDIV_MADDU: r = acc + ua * ub;
      MULDIV_MSUB:  r = acc - sa * sb;
      MULDIV_MSUBU: r = acc - ua * ub;
      MULDIV_DIV: begin
        if (bv == '0) r = {av, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      MULDIV_DIVU: begin
        if (bv == '0) r = {av, 32'hFFFF_FFFF};
        else begin
          sq = ua / ub;
          sr = ua % ub;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: r = '0;
    endcase
    return result_t'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse; returns sampling in cycle 1 (the edge that accepted it is edge 0).
  task automatic launch(input muldiv_funct_t f, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] hv, input logic [W-1:0] lv);
    funct = f;
    a     = av;
    b     = bv;
    hi_in = hv;
    lo_in = lv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input muldiv_funct_t f, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] hv, input logic [W-1:0] lv, input bit pokeBusy);
    result_t e;
    int lat, doneCycle, busyBad;
    e = modelResult(f, av, bv, hv, lv);
    expQ.push_back(e);
    lastExp = e;
    lat = (f inside {MULDIV_DIV, MULDIV_DIVU}) ? divLat : mulLat;
    launch(f, av, bv, hv, lv);
    if (pokeBusy) begin
      start = 1'b1;
      funct = MULDIV_DIVU;
      a     = ~av;
      b     = 32'd3;
    end
    doneCycle = 0;
    busyBad   = 0;
    for (int c = 1; c <= 80; c++) begin
      if (busy !== 1'b1) busyBad++;
      if (done === 1'b1) begin
        doneCycle = c;
        break;
      end
      tick();
    end
    start = 1'b0;
    checkOutput("latency", 64'(doneCycle), 64'(lat));
    checkOutput("busyWindow", 64'(busyBad), 64'd0);
    tick();
    checkOutput("donePulse", {63'b0, done}, 64'd0);
    checkOutput("idleAfter", {63'b0, busy}, 64'd0);
  endtask

  // Scoreboard drain: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousDone", 64'd1, 64'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("hi", {32'b0, hi_out}, {32'b0, monExp.hi});
        checkOutput("lo", {32'b0, lo_out}, {32'b0, monExp.lo});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("rstBusy", {63'b0, busy}, 64'd0);
    checkOutput("rstDone", {63'b0, done}, 64'd0);
    checkOutput("rstHi", {32'b0, hi_out}, 64'd0);
    checkOutput("rstLo", {32'b0, lo_out}, 64'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus(MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    applyStimulus(MULDIV_MULT,  32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0, 1'b0);
    applyStimulus(MULDIV_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(MULDIV_MSUB,  32'd1, 32'd1, 32'h0, 32'h0, 1'b0);
    applyStimulus(MULDIV_DIV,   32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b0);
    applyStimulus(MULDIV_DIVU,  32'd7, 32'd0, 32'h0, 32'h0, 1'b0);
    applyStimulus(MULDIV_DIV,   32'hFFFF_FFF9, 32'd0, 32'h0, 32'h0, 1'b0);
    applyStimulus(MULDIV_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
    applyStimulus(MULDIV_MULT,  32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b1);

    funct = MULDIV_NCARE;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("ncareIgnored", {63'b0, busy}, 64'd0);

    funct = MULDIV_DIVU;
    a     = 32'd9;
    b     = 32'd2;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flushBeatsStart", {63'b0, busy}, 64'd0);

    launch(MULDIV_DIV, 32'd100, 32'd3, 32'h0, 32'h0);
    repeat (9) tick();
    checkOutput("busyBeforeFlush", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushBusy", {63'b0, busy}, 64'd0);
    sawDone = 1'b0;
    repeat (40) begin
      tick();
      if (done !== 1'b0) sawDone = 1'b1;
    end
    checkOutput("flushNoDone", {63'b0, sawDone}, 64'd0);
    checkOutput("flushHiHeld", {32'b0, hi_out}, {32'b0, lastExp.hi});
    checkOutput("flushLoHeld", {32'b0, lo_out}, {32'b0, lastExp.lo});
    applyStimulus(MULDIV_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 6; i++)
      applyStimulus(opTable[$urandom_range(0, 7)], $urandom, $urandom, $urandom, $urandom, 1'b0);

    launch(MULDIV_MULTU, 32'd12345, 32'd678, 32'h0, 32'h0);
    repeat (rstCycle - 1) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midRstBusy", {63'b0, busy}, 64'd0);
    checkOutput("midRstDone", {63'b0, done}, 64'd0);
    checkOutput("midRstHi", {32'b0, hi_out}, 64'd0);
    checkOutput("midRstLo", {32'b0, lo_out}, 64'd0);
    tick();
    checkOutput("postRstIdle", {63'b0, busy}, 64'd0);

    applyStimulus(MULDIV_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0002, 1'b0);
    tick();
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
